// File: rtl/noc_router.sv
// Five-port mesh router: per-input FIFOs, XY routing, and per-output
// round-robin arbitration locked for the length of each wormhole packet.
module noc_router #(
  parameter int unsigned X_COORD    = 0,
  parameter int unsigned Y_COORD    = 0,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned PAYLOAD_W  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PAYLOAD_W:0]   in_flit [5],
  input  logic [4:0]           in_enable,
  output logic [4:0]           in_ack,
  output logic [PAYLOAD_W:0]   out_flit [5],
  output logic [4:0]           out_enable,
  input  logic [4:0]           out_ack,
  output logic [7:0]           drop_cnt
);
  localparam int unsigned FLIT_W = PAYLOAD_W + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [2:0]  NORTH = 3'd0, EAST = 3'd1, SOUTH = 3'd2, WEST = 3'd3, LOCAL = 3'd4;

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, FORWARD} state_t;

  logic [FLIT_W-1:0] mem [5][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [5];
  logic [PTR_W-1:0]  rd_ptr [5];
  logic [CNT_W-1:0]  count  [5];
  state_t            state  [5];
  logic [2:0]        route  [5];
  logic [7:0]        remain [5];
  logic              active;

  logic [4:0]        locked;
  logic [2:0]        owner  [5];
  logic [2:0]        rr_ptr [5];

  logic [FLIT_W-1:0] head       [5];
  logic [2:0]        head_route [5];
  logic [4:0]        empty, full, push, pop, drop, xfer, done, gnt_in;
  logic [4:0]        gnt_vld, release_c;
  logic [2:0]        gnt_idx [5];
  logic [3:0]        rr_sum;
  logic [2:0]        cand;
  logic [8:0]        drop_sum;

  function automatic logic [2:0] xy_route(input logic [FLIT_W-1:0] f);
    logic [ADDR_W-1:0] dx;
    logic [ADDR_W-1:0] dy;
    dx = f[2*ADDR_W-1:ADDR_W];
    dy = f[ADDR_W-1:0];
    if (dx > ADDR_W'(X_COORD))      return EAST;
    else if (dx < ADDR_W'(X_COORD)) return WEST;
    else if (dy > ADDR_W'(Y_COORD)) return NORTH;
    else if (dy < ADDR_W'(Y_COORD)) return SOUTH;
    else                            return LOCAL;
  endfunction

  // Input side: FIFO status, drop of stray DATA / U-turn headers, output transfers
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      head[i]       = mem[i][rd_ptr[i]];
      head_route[i] = xy_route(head[i]);
      empty[i]      = (count[i] == '0);
      full[i]       = (count[i] == CNT_W'(FIFO_DEPTH));
      in_ack[i]     = active & ~full[i];
      push[i]       = in_enable[i] & in_ack[i];
      drop[i]       = (state[i] == IDLE) && !empty[i] &&
                      (!head[i][PAYLOAD_W] || ((head_route[i] == 3'(i)) && (i != 4)));
      xfer[i]       = (state[i] == FORWARD) && !empty[i] && out_ack[route[i]];
      done[i]       = xfer[i] && (head[i][PAYLOAD_W] ? (remain[i] == 8'd0) : (remain[i] == 8'd1));
      pop[i]        = drop[i] | xfer[i];
    end
    drop_sum = 9'(drop_cnt) + 9'($countones(drop));
  end

  // Output side: round-robin search from rr_ptr, allowed the cycle the lock releases
  always_comb begin
    rr_sum  = '0;
    cand    = '0;
    gnt_in  = '0;
    for (int o = 0; o < 5; o++) begin
      release_c[o] = locked[o] && done[owner[o]];
      gnt_vld[o]   = 1'b0;
      gnt_idx[o]   = '0;
      for (int k = 0; k < 5; k++) begin
        rr_sum = 4'(rr_ptr[o]) + 4'(k);
        cand   = (rr_sum >= 4'd5) ? 3'(rr_sum - 4'd5) : 3'(rr_sum);
        if (!gnt_vld[o] && (!locked[o] || release_c[o]) &&
            (state[cand] == WAIT_GRANT) && (route[cand] == 3'(o)) &&
            ((cand != 3'(o)) || (o == 4))) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = cand;
        end
      end
      out_enable[o] = locked[o] && (state[owner[o]] == FORWARD) && !empty[owner[o]];
      out_flit[o]   = out_enable[o] ? head[owner[o]] : '0;
    end
    for (int i = 0; i < 5; i++)
      for (int o = 0; o < 5; o++)
        if (gnt_vld[o] && (gnt_idx[o] == 3'(i))) gnt_in[i] = 1'b1;
  end

  // FIFO storage needs no reset: nothing reads an entry before it is written
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= in_flit[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      drop_cnt <= '0;
      locked   <= '0;
      for (int i = 0; i < 5; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        state[i]  <= IDLE;
        route[i]  <= '0;
        remain[i] <= '0;
        owner[i]  <= '0;
        rr_ptr[i] <= NORTH;
      end
    end else begin
      active   <= 1'b1;
      drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      for (int i = 0; i < 5; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        case (state[i])
          IDLE: if (!empty[i] && !drop[i]) begin
            state[i] <= WAIT_GRANT;
            route[i] <= head_route[i];
          end
          WAIT_GRANT: if (gnt_in[i]) begin
            state[i]  <= FORWARD;
            remain[i] <= head[i][2*ADDR_W+7:2*ADDR_W];
          end
          FORWARD: begin
            if (xfer[i] && !head[i][PAYLOAD_W]) remain[i] <= remain[i] - 8'd1;
            if (done[i]) state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase
      end
      for (int o = 0; o < 5; o++) begin
        if (gnt_vld[o]) begin
          locked[o] <= 1'b1;
          owner[o]  <= gnt_idx[o];
          rr_ptr[o] <= (gnt_idx[o] == LOCAL) ? NORTH : gnt_idx[o] + 3'd1;
        end else if (release_c[o]) begin
          locked[o] <= 1'b0;
        end
      end
    end
  end
endmodule
